am2909_seq: RTL and testbench

- 4-bit microprogram sequencer slice with a registered microprogram counter (uPC), an address register (AR) and a push/pop return stack.
- Consumes the OR-mask produced by the 16-way branch control unit on its `orx` input and merges it into the selected next address.
- Feeds the control store address bus.
- Slices cascade through `cn` and `c4` for wider microaddresses.

---
 rtl/am2909_seq_if.sv | 29 ++
 rtl/am2909_seq.sv | 96 +++++++++
 tb/tb_am2909_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/am2909_seq_if.sv
// Control/status bundle of the am2909_seq sequencer slice (y stays a plain tri-state pin).
// STACK_STATUS_EN adds the full/empty stack flags.
interface am2909_seq_if;
  logic [3:0] d;
  logic [3:0] r;
  logic [3:0] orx;
  logic [1:0] s;
  logic       re_;
  logic       fe_;
  logic       pup;
  logic       zero_;
  logic       oe_;
  logic       cn;
  logic       c4;
`ifdef STACK_STATUS_EN
  logic       full;
  logic       empty;

  modport master (output d, r, orx, s, re_, fe_, pup, zero_, oe_, cn,
                  input  c4, full, empty);
  modport slave  (input  d, r, orx, s, re_, fe_, pup, zero_, oe_, cn,
                  output c4, full, empty);
`else
  modport master (output d, r, orx, s, re_, fe_, pup, zero_, oe_, cn,
                  input  c4);
  modport slave  (input  d, r, orx, s, re_, fe_, pup, zero_, oe_, cn,
                  output c4);
`endif
endinterface

// File: rtl/am2909_seq.sv
// 4-bit microprogram sequencer slice: uPC, address register, return stack, OR-merge.
// STACK_STATUS_EN: occupancy counter with full/empty flags, push-when-full and pop-when-empty ignored.
module am2909_seq #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  am2909_seq_if.slave       bus,
  output wire  [3:0]        y
);
  localparam int unsigned PW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [3:0]    r_upc;
  logic [3:0]    r_ar;
  logic [PW-1:0] r_sp;
  logic [3:0]    r_stk [STACK_DEPTH];

  logic [3:0]    w_mux;
  logic [3:0]    w_ya;
  logic [PW-1:0] w_sp_inc;
  logic [PW-1:0] w_sp_dec;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Source select feeding the OR-merge
  always_comb begin
    w_mux = r_upc;
    case (bus.s)
      2'b00:   w_mux = r_upc;
      2'b01:   w_mux = r_ar;
      2'b10:   w_mux = r_stk[r_sp];
      default: w_mux = bus.d;
    endcase
  end

  assign w_ya     = bus.zero_ ? (w_mux | bus.orx) : 4'b0000;
  assign y        = bus.oe_ ? 4'bzzzz : w_ya;
  assign bus.c4   = bus.cn & (w_ya == 4'hF);
  assign w_sp_inc = r_sp + PW'(1);
  assign w_sp_dec = r_sp - PW'(1);

`ifdef STACK_STATUS_EN
  logic [CW-1:0] r_cnt;

  assign w_push_ok = (r_cnt != CW'(STACK_DEPTH));
  assign w_pop_ok  = (r_cnt != '0);
  assign bus.full  = ~w_push_ok;
  assign bus.empty = ~w_pop_ok;

  // Occupancy tracks only the stack operations that were accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!bus.fe_) begin
      if (bus.pup && w_push_ok)
        r_cnt <= r_cnt + CW'(1);
      else if (!bus.pup && w_pop_ok)
        r_cnt <= r_cnt - CW'(1);
    end
  end
`else
  assign w_push_ok = 1'b1;
  assign w_pop_ok  = 1'b1;
`endif

  // uPC and AR; the uPC advances every cycle regardless of oe_
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upc <= '0;
      r_ar  <= '0;
    end else begin
      r_upc <= w_ya + 4'(bus.cn);
      if (!bus.re_)
        r_ar <= bus.r;
    end
  end

  // Return stack; a push saves the pre-edge uPC as the return address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++)
        r_stk[i] <= '0;
    end else if (!bus.fe_) begin
      if (bus.pup) begin
        if (w_push_ok) begin
          r_sp            <= w_sp_inc;
          r_stk[w_sp_inc] <= r_upc;
        end
      end else if (w_pop_ok) begin
        r_sp <= w_sp_dec;
      end
    end
  end
endmodule

// File: tb/tb_am2909_seq.sv
// Scoreboard bench for am2909_seq: directed scenarios plus random traffic against a reference model.
module tb_am2909_seq;
  localparam int DEPTH = 4;

  typedef struct {
    logic       rst;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] r;
    logic [3:0] orx;
    logic       re_;
    logic       fe_;
    logic       pup;
    logic       zero_;
    logic       oe_;
    logic       cn;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       chk_y;
    logic [3:0] y;
    logic       c4;
    logic       full;
    logic       empty;
  } exp_t;

  logic      clk;
  logic      rst;
  wire [3:0] y;
  int        checks;
  int        errors;
  int        cyc;
  exp_t      exp_q[$];

  am2909_seq_if bus ();

  am2909_seq #(.STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .y   (y)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [3:0] m_upc;
  logic [3:0] m_ar;
  logic [3:0] m_stk [DEPTH];
  int         m_sp;
  int         m_cnt;

  function automatic void model_clear();
    m_upc = 0; m_ar = 0; m_sp = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
  endfunction

  function automatic logic [3:0] model_ya(input stim_t st);
    logic [3:0] src;
    case (st.s)
      2'b00:   src = m_upc;
      2'b01:   src = m_ar;
      2'b10:   src = m_stk[m_sp];
      default: src = st.d;
    endcase
    return st.zero_ ? (src | st.orx) : 4'b0000;
  endfunction

  function automatic bit status_en();
`ifdef STACK_STATUS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_edge(input stim_t st, input logic [3:0] ya);
    logic [3:0] old_upc;
    if (st.rst) begin
      model_clear();
      return;
    end
    old_upc = m_upc;
    m_upc = 4'((int'(ya) + int'(st.cn)) % 16);
    if (!st.re_) m_ar = st.r;
    if (!st.fe_) begin
      if (st.pup) begin
        if (!status_en() || m_cnt < DEPTH) begin
          m_sp = (m_sp + 1) % DEPTH;
          m_stk[m_sp] = old_upc;
          m_cnt++;
        end
      end else if (!status_en() || m_cnt > 0) begin
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
    end
  endfunction

  function automatic stim_t idle();
    stim_t st;
    st.rst = 0; st.s = 2'b00; st.d = 0; st.r = 0; st.orx = 0;
    st.re_ = 1; st.fe_ = 1; st.pup = 0; st.zero_ = 1; st.oe_ = 0; st.cn = 0;
    return st;
  endfunction

  task automatic step(input stim_t st);
    exp_t       e;
    logic [3:0] ya;
    rst = st.rst; bus.s = st.s; bus.d = st.d; bus.r = st.r; bus.orx = st.orx;
    bus.re_ = st.re_; bus.fe_ = st.fe_; bus.pup = st.pup; bus.zero_ = st.zero_;
    bus.oe_ = st.oe_; bus.cn = st.cn;
    ya      = model_ya(st);
    e.cyc   = cyc;
    e.chk_y = !st.oe_;
    e.y     = ya;
    e.c4    = st.cn && (ya == 4'hF);
    e.full  = (m_cnt == DEPTH);
    e.empty = (m_cnt == 0);
    exp_q.push_back(e);
    model_edge(st, ya);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: the DUT presents y/c4 every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_y) begin
          checks++;
          if (y !== e.y) begin
            errors++;
            $display("FAIL y cyc=%0d got=%h exp=%h", e.cyc, y, e.y);
          end
        end
        checks++;
        if (bus.c4 !== e.c4) begin
          errors++;
          $display("FAIL c4 cyc=%0d got=%b exp=%b", e.cyc, bus.c4, e.c4);
        end
`ifdef STACK_STATUS_EN
        checks++;
        if (bus.full !== e.full || bus.empty !== e.empty) begin
          errors++;
          $display("FAIL flags cyc=%0d got full=%b empty=%b exp full=%b empty=%b",
                   e.cyc, bus.full, bus.empty, e.full, e.empty);
        end
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t st;
    clk = 0; checks = 0; errors = 0; cyc = 0;
    st = idle(); st.rst = 1;
    rst = 1; bus.s = 0; bus.d = 0; bus.r = 0; bus.orx = 0; bus.re_ = 1;
    bus.fe_ = 1; bus.pup = 0; bus.zero_ = 1; bus.oe_ = 0; bus.cn = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state, then uPC count 0..F,0,1 with c4 at F
    step(idle());
    for (int i = 0; i < 18; i++) begin
      st = idle(); st.cn = 1; step(st);
    end

    // Branch merge: d=1000 | orx=0101 -> 1101, uPC becomes 1110
    st = idle(); st.s = 2'b11; st.d = 4'b1000; st.orx = 4'b0101; st.cn = 1; step(st);
    step(idle());

    // Call then return
    st = idle(); st.rst = 1; step(st);
    st = idle(); st.s = 2'b11; st.d = 4'd2; st.cn = 1; step(st);
    st = idle(); st.s = 2'b11; st.d = 4'd9; st.fe_ = 0; st.pup = 1; st.cn = 1; step(st);
    step(idle());
    st = idle(); st.s = 2'b10; st.fe_ = 0; st.pup = 0; st.cn = 1; step(st);
    step(idle());
    st = idle(); st.s = 2'b10; step(st);

    // AR load with same-cycle read, then forced zero
    st = idle(); st.s = 2'b01; st.re_ = 0; st.r = 4'd7; step(st);
    st = idle(); st.s = 2'b01; step(st);
    st = idle(); st.s = 2'b11; st.d = 4'hA; st.orx = 4'hF; st.zero_ = 0; st.cn = 1; step(st);

    // Stack limits: five pushes, five pops
    st = idle(); st.rst = 1; step(st);
    for (int i = 0; i < 5; i++) begin
      st = idle(); st.cn = 1; st.fe_ = 0; st.pup = 1; step(st);
    end
    for (int i = 0; i < 5; i++) begin
      st = idle(); st.s = 2'b10; st.fe_ = 0; st.pup = 0; step(st);
    end
    st = idle(); st.s = 2'b10; step(st);

    // Reset mid-operation overrides push and AR load
    st = idle(); st.cn = 1; st.fe_ = 0; st.pup = 1; step(st);
    st = idle(); st.rst = 1; st.fe_ = 0; st.pup = 1; st.re_ = 0; st.r = 4'hC; st.cn = 1; step(st);
    st = idle(); st.s = 2'b10; step(st);
    st = idle(); st.s = 2'b01; step(st);
    step(idle());

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      st.rst   = ($urandom_range(0, 39) == 0);
      st.s     = 2'($urandom_range(0, 3));
      st.d     = 4'($urandom_range(0, 15));
      st.r     = 4'($urandom_range(0, 15));
      st.orx   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      st.re_   = 1'($urandom_range(0, 1));
      st.fe_   = 1'($urandom_range(0, 1));
      st.pup   = 1'($urandom_range(0, 1));
      st.zero_ = ($urandom_range(0, 7) != 0);
      st.oe_   = ($urandom_range(0, 7) == 0);
      st.cn    = 1'($urandom_range(0, 1));
      step(st);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
